// File: rtl/pcpi_serial_bridge_pkg.sv
// Shared types and elaboration helpers for the PCPI pin-serial bridge.
package pcpi_bridge_pkg;

   // Bridge states; the capture half (IDLE/REL) lives in seg_handshake_rx,
   // the issue/response half (ISSUE/RESP/RESP_REL) in the top level.
   typedef enum logic [2:0] {
      IDLE,
      REL,
      ISSUE,
      RESP,
      RESP_REL
   } state_t;

   // Number of host segments per instruction/result word.
   function automatic int nseg(input int insn_w, input int seg_w);
      return insn_w / seg_w;
   endfunction

   // Width of a segment index register; at least one bit.
   function automatic int idx_w(input int insn_w, input int seg_w);
      return (insn_w / seg_w > 1) ? $clog2(insn_w / seg_w) : 1;
   endfunction

   // Timeout counter width, wide enough to hold TIMEOUT_CYC itself.
   function automatic int cnt_w(input int timeout_cyc);
      return $clog2(timeout_cyc + 1);
   endfunction

   // Instruction width must split evenly into segments.
   function automatic bit seg_fit(input int insn_w, input int seg_w);
      return (insn_w % seg_w) == 0;
   endfunction

endpackage

// File: rtl/pcpi_serial_bridge_if.sv
// Host segment bus plus PCPI bus of the serial bridge.
interface pcpi_serial_bridge_if #(
   parameter int SEG_W  = 4,
   parameter int INSN_W = 32
);
   logic [SEG_W-1:0]  seg_in;
   logic              seg_valid;
   logic              seg_ack;
   logic              pcpi_valid;
   logic [INSN_W-1:0] pcpi_insn;
   logic              pcpi_ready;
   logic              pcpi_wr;
   logic              pcpi_wait;
   logic [INSN_W-1:0] pcpi_rd;
   logic [SEG_W-1:0]  rd_out;
   logic              rd_valid;
   logic              rd_ack;
   logic              busy;
   logic              err_timeout;

   // Bridge side.
   modport slave (
      input  seg_in, seg_valid, pcpi_ready, pcpi_wr, pcpi_wait, pcpi_rd, rd_ack,
      output seg_ack, pcpi_valid, pcpi_insn, rd_out, rd_valid, busy, err_timeout
   );

   // Host / co-processor side.
   modport master (
      output seg_in, seg_valid, pcpi_ready, pcpi_wr, pcpi_wait, pcpi_rd, rd_ack,
      input  seg_ack, pcpi_valid, pcpi_insn, rd_out, rd_valid, busy, err_timeout
   );
endinterface

// File: rtl/pcpi_serial_bridge_rx.sv
// Four-phase segment capture: assembles the instruction LSB segment first.
module seg_handshake_rx
   import pcpi_bridge_pkg::*;
#(
   parameter int SEG_W  = 4,
   parameter int INSN_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,         // top is idle, capture allowed
   input  logic              seg_valid,
   input  logic [SEG_W-1:0]  seg_in,
   output logic              seg_ack,
   output logic [INSN_W-1:0] insn,
   output logic              first_cap,  // segment 0 captured this cycle
   output logic              last_rel,   // last segment released this cycle
   output logic              busy_nxt    // capture side non-idle next cycle
);
   localparam int IDX_W = idx_w(INSN_W, SEG_W);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(nseg(INSN_W, SEG_W) - 1);

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [INSN_W-1:0] insn_q, insn_d;
   logic              ack_q, ack_d;

   // Next-state: capture once per high phase, advance index on release.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      insn_d    = insn_q;
      ack_d     = ack_q;
      first_cap = 1'b0;
      last_rel  = 1'b0;
      case (state_q)
         IDLE: begin
            if (en && seg_valid) begin
               insn_d[idx_q*SEG_W +: SEG_W] = seg_in;
               ack_d     = 1'b1;
               first_cap = (idx_q == '0);
               state_d   = REL;
            end
         end
         REL: begin
            if (!seg_valid) begin
               ack_d   = 1'b0;
               state_d = IDLE;
               if (idx_q == LAST) begin
                  idx_d    = '0;
                  last_rel = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      busy_nxt = (state_d != IDLE) || (idx_d != '0);
   end

   // State and capture registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         insn_q  <= '0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         insn_q  <= insn_d;
         ack_q   <= ack_d;
      end
   end

   assign seg_ack = ack_q;
   assign insn    = insn_q;
endmodule

// File: rtl/pcpi_serial_bridge.sv
// PCPI pin-serial bridge: serial instruction in, PCPI issue with timeout,
// serial result out.
module pcpi_serial_bridge
   import pcpi_bridge_pkg::*;
#(
   parameter int SEG_W       = 4,
   parameter int INSN_W      = 32,
   parameter int TIMEOUT_CYC = 16
) (
   input logic clk,
   input logic rst_n,
   pcpi_serial_bridge_if.slave bus
);
   localparam int IDX_W = idx_w(INSN_W, SEG_W);
   localparam int CNT_W = cnt_w(TIMEOUT_CYC);
   localparam logic [IDX_W-1:0] LAST   = IDX_W'(nseg(INSN_W, SEG_W) - 1);
   localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYC - 1);

   if (!seg_fit(INSN_W, SEG_W)) begin : g_bad_width
      $error("INSN_W must be a multiple of SEG_W");
   end

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  ridx_q, ridx_d;
   logic [INSN_W-1:0] res_q, res_d;
   logic              err_q, err_d;
   logic              pv_q, rv_q, busy_q;
   logic [SEG_W-1:0]  rd_out_q, rd_out_d;
   logic              first_cap, last_rel, rx_busy_nxt;

   seg_handshake_rx #(.SEG_W(SEG_W), .INSN_W(INSN_W)) u_rx (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (state_q == IDLE),
      .seg_valid (bus.seg_valid),
      .seg_in    (bus.seg_in),
      .seg_ack   (bus.seg_ack),
      .insn      (bus.pcpi_insn),
      .first_cap (first_cap),
      .last_rel  (last_rel),
      .busy_nxt  (rx_busy_nxt)
   );

   // Next-state: issue, timeout supervision and result serialisation.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ridx_d  = ridx_q;
      res_d   = res_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (first_cap) err_d = 1'b0;
            if (last_rel) state_d = ISSUE;
         end
         ISSUE: begin
            // ready takes priority over an expiry in the same cycle
            if (bus.pcpi_ready) begin
               cnt_d = '0;
               if (bus.pcpi_wr) begin
                  res_d   = bus.pcpi_rd;
                  state_d = RESP;
               end else begin
                  state_d = IDLE;
               end
            end else if (bus.pcpi_wait) begin
               cnt_d = '0;
            end else if (cnt_q == TO_MAX) begin
               cnt_d   = '0;
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            if (bus.rd_ack) state_d = RESP_REL;
         end
         RESP_REL: begin
            if (!bus.rd_ack) begin
               if (ridx_q == LAST) begin
                  ridx_d  = '0;
                  state_d = IDLE;
               end else begin
                  ridx_d  = ridx_q + 1'b1;
                  state_d = RESP;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      rd_out_d = (state_d == RESP) ? res_d[ridx_d*SEG_W +: SEG_W] : '0;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Datapath and registered outputs, all derived from next-state values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         ridx_q   <= '0;
         res_q    <= '0;
         err_q    <= 1'b0;
         pv_q     <= 1'b0;
         rv_q     <= 1'b0;
         busy_q   <= 1'b0;
         rd_out_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         ridx_q   <= ridx_d;
         res_q    <= res_d;
         err_q    <= err_d;
         pv_q     <= (state_d == ISSUE);
         rv_q     <= (state_d == RESP);
         busy_q   <= (state_d != IDLE) || (ridx_d != '0) || rx_busy_nxt;
         rd_out_q <= rd_out_d;
      end
   end

   assign bus.pcpi_valid  = pv_q;
   assign bus.rd_valid    = rv_q;
   assign bus.rd_out      = rd_out_q;
   assign bus.busy        = busy_q;
   assign bus.err_timeout = err_q;
endmodule
